lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store sequencer that consumes the decoded control bits (mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i) at the memory stage.
- Runs a request/grant/response handshake with the data memory, stalls the pipeline while an access is outstanding, and produces one registered writeback per instruction.
- Non-memory instructions pass straight through to writeback with 1-cycle latency.

Parameters:
- ADDR_W, 32, data memory byte-address width
- DATA_W, 32, data word width
- RD_W, 5, destination register index width
- TIMEOUT_CYC, 64, cycles allowed per REQ or WAIT_R before abort (used only with LSU_TIMEOUT_EN)

Ports:
- clk_i  in  1  clock, rising edge
- reset_i  in  1  synchronous active-high reset
- valid_i  in  1  instruction present at memory stage
- mem_read_i / mem_write_i / mem_to_reg_i / reg_write_i  in  1 each  decoded control bits
- alu_res_i  in  DATA_W  ALU result; doubles as address (low ADDR_W bits)
- wdata_i  in  DATA_W  store data
- rd_i  in  RD_W  destination register
- stall_o  out  1  hold upstream stages
- req_o  out  1  memory request
- we_o  out  1  request is a write
- maddr_o  out  ADDR_W  memory address
- mwdata_o  out  DATA_W  memory write data
- gnt_i  in  1  memory accepted request
- rvalid_i  in  1  read data valid
- rdata_i  in  DATA_W  read data
- wb_valid_o  out  1  writeback strobe (1 cycle)
- wb_rd_o  out  RD_W  writeback register
- wb_data_o  out  DATA_W  writeback data
- err_o  out  1  1-cycle error pulse

Behaviour:
- Reset: state IDLE; req_o, we_o, wb_valid_o, err_o = 0; maddr_o, mwdata_o, wb_rd_o, wb_data_o = 0. Reset mid-access abandons it. A later rvalid_i/gnt_i is ignored. No writeback is issued.
- FSM states: IDLE, REQ, WAIT_R.
- IDLE, accepting valid_i:
  - mem_read_i & mem_write_i both set: illegal. No access, no writeback, err_o pulses next cycle.
  - mem_read_i or mem_write_i: latch address, wdata, rd, we = mem_write_i and wb-enable = reg_write_i & mem_to_reg_i. Go to REQ.
  - otherwise: if reg_write_i, next cycle wb_valid_o=1, wb_data_o=alu_res_i, wb_rd_o=rd_i.
- REQ: req_o=1 with stable we_o/maddr_o/mwdata_o until gnt_i.
  - On gnt_i: a store returns to IDLE; a load goes to WAIT_R.
  - req_o drops the cycle after grant.
- WAIT_R: on rvalid_i, capture rdata_i and return to IDLE. wb_valid_o=1 next cycle with wb_data_o=rdata_i, if wb-enable is set.
  - rvalid_i in the same cycle as gnt_i is outside the protocol: the response must arrive at least 1 cycle after grant.
- stall_o = (state != IDLE) | (state == IDLE & valid_i & (mem_read_i | mem_write_i)). This is combinational. It deasserts in the cycle the FSM re-enters IDLE.
- Minimum latency:
  - load: accept cycle 0, gnt cycle 1, rvalid cycle 2, wb_valid_o cycle 3.
  - store: stall released at cycle 2.
- rd == 0: wb_valid_o is suppressed on all paths.
- rvalid_i outside WAIT_R and gnt_i outside REQ are ignored.
- Back-to-back: a new instruction may be accepted in the same cycle the FSM sits in IDLE, including the cycle wb_valid_o is high for the previous one.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined: a counter resets on entry to REQ and to WAIT_R. If it reaches TIMEOUT_CYC-1 without gnt_i or rvalid_i:
  - FSM goes to IDLE and req_o drops.
  - err_o pulses 1 cycle.
  - no writeback is issued.
  - late responses are ignored.
- Undefined: no counter; the FSM waits indefinitely. err_o is driven only by the illegal-control case.

Decomposition:
- Package lsu_pkg: state enum (IDLE, REQ, WAIT_R), default ADDR_W/DATA_W/RD_W, timeout counter width = $clog2(TIMEOUT_CYC).
- One sub-module, lsu_watchdog: counter with clear, enable and expire output. It is instantiated only under LSU_TIMEOUT_EN.

Test Plan:
- ALU op: valid_i, reg_write_i=1, rd_i=5, alu_res_i=0x1234 -> wb_valid_o=1 next cycle, wb_rd_o=5, wb_data_o=0x1234, stall_o=0 throughout.
- Load: mem_read_i/mem_to_reg_i/reg_write_i=1, alu_res_i=0x40, rd_i=7; gnt_i at cycle 1, rvalid_i with rdata_i=0xDEADBEEF at cycle 2 -> req_o=1 and maddr_o=0x40 at cycle 1; wb_valid_o, wb_rd_o=7, wb_data_o=0xDEADBEEF at cycle 3; stall_o high cycles 0-2.
- Store with 4-cycle grant delay: mem_write_i=1, alu_res_i=0x80, wdata_i=0xA5A5A5A5 -> req_o, we_o, maddr_o and mwdata_o held stable 4 cycles; IDLE after gnt_i; no wb_valid_o.
- Illegal control: mem_read_i=mem_write_i=1 -> err_o single pulse, req_o never asserted, no writeback.
- Reset mid-load: reset_i asserted in WAIT_R, then rvalid_i=1 -> all outputs 0, state IDLE, no wb_valid_o.
- LSU_TIMEOUT_EN, TIMEOUT_CYC=8, gnt_i held 0 -> req_o drops and err_o pulses after 8 REQ cycles; stall_o releases; a following ALU op completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store sequencer.
//   - lsu_state_t : sequencer states (IDLE, REQ, WAIT_R)
//   - LSU_*       : default widths and timeout length
//   - tmo_width() : width of the timeout counter for a given cycle budget
package lsu_pkg;

    localparam int LSU_ADDR_W      = 32;
    localparam int LSU_DATA_W      = 32;
    localparam int LSU_RD_W        = 5;
    localparam int LSU_TIMEOUT_CYC = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } lsu_state_t;

    // Counter must hold TIMEOUT_CYC-1; never narrower than one bit.
    function automatic int tmo_width(input int cyc);
        return (cyc > 2) ? $clog2(cyc) : 1;
    endfunction

    localparam int LSU_TMO_W = tmo_width(LSU_TIMEOUT_CYC);

endpackage

// File: rtl/lsu_watchdog.sv
// Cycle counter guarding one outstanding memory phase.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   clr_i          : restart count at zero (priority over en_i)
//   en_i           : count while a phase is outstanding
//   expire_o       : high while enabled and count == CYC-1
// Only instantiated when LSU_TIMEOUT_EN is defined.
module lsu_watchdog
    import lsu_pkg::*;
#(
    parameter int CYC = LSU_TIMEOUT_CYC
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int W = tmo_width(CYC);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign expire_o = en_i & (r_cnt == W'(CYC - 1));

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Memory-stage load/store sequencer.
// Consumes decoded control bits, runs a req/gnt/rvalid handshake with data
// memory, stalls upstream while an access is outstanding and issues one
// registered writeback per instruction (ALU results pass through in 1 cycle).
// Ports:
//   clk_i, reset_i                 : clock, synchronous active-high reset
//   valid_i, mem_*_i, reg_write_i  : instruction at memory stage + controls
//   alu_res_i, wdata_i, rd_i       : address/ALU result, store data, dest reg
//   stall_o                        : hold upstream (combinational)
//   req_o, we_o, maddr_o, mwdata_o : memory request side
//   gnt_i, rvalid_i, rdata_i       : memory grant / response side
//   wb_valid_o, wb_rd_o, wb_data_o : writeback (1-cycle strobe)
//   err_o                          : 1-cycle error pulse
// Build option: define LSU_TIMEOUT_EN to abort REQ/WAIT_R after TIMEOUT_CYC
// cycles with an err_o pulse; otherwise the sequencer waits indefinitely.
//
// state  | meaning
// IDLE   | ready; accepts a new instruction every cycle
// REQ    | req_o held with stable address/data until gnt_i
// WAIT_R | load granted, waiting for rvalid_i
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = LSU_ADDR_W,
    parameter int DATA_W      = LSU_DATA_W,
    parameter int RD_W        = LSU_RD_W,
    parameter int TIMEOUT_CYC = LSU_TIMEOUT_CYC
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              valid_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              mem_to_reg_i,
    input  logic              reg_write_i,
    input  logic [DATA_W-1:0] alu_res_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [RD_W-1:0]   rd_i,
    output logic              stall_o,
    output logic              req_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] maddr_o,
    output logic [DATA_W-1:0] mwdata_o,
    input  logic              gnt_i,
    input  logic              rvalid_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              wb_valid_o,
    output logic [RD_W-1:0]   wb_rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              err_o
);

    lsu_state_t        r_state;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_maddr;
    logic [DATA_W-1:0] r_mwdata;
    logic [RD_W-1:0]   r_rd;
    logic              r_wb_en;
    logic              r_wb_valid;
    logic [RD_W-1:0]   r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_err;

    logic w_is_mem;
    logic w_rd_nz;
    logic w_expire;

    assign w_is_mem = mem_read_i | mem_write_i;
    assign w_rd_nz  = (rd_i != '0);

`ifdef LSU_TIMEOUT_EN
    logic w_wd_clr;
    logic w_wd_en;

    // Clearing in IDLE and on grant restarts the count on entry to REQ and WAIT_R.
    assign w_wd_en  = (r_state == REQ) | (r_state == WAIT_R);
    assign w_wd_clr = (r_state == IDLE) | ((r_state == REQ) & gnt_i);

    lsu_watchdog #(
        .CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clr_i    (w_wd_clr),
        .en_i     (w_wd_en),
        .expire_o (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_maddr    <= '0;
            r_mwdata   <= '0;
            r_rd       <= '0;
            r_wb_en    <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        if (mem_read_i && mem_write_i) begin
                            r_err <= 1'b1;
                        end else if (w_is_mem) begin
                            r_maddr  <= alu_res_i[ADDR_W-1:0];
                            r_mwdata <= wdata_i;
                            r_rd     <= rd_i;
                            r_we     <= mem_write_i;
                            // rd==0 suppression is folded into the enable here.
                            r_wb_en  <= reg_write_i & mem_to_reg_i & w_rd_nz;
                            r_req    <= 1'b1;
                            r_state  <= REQ;
                        end else if (reg_write_i && w_rd_nz) begin
                            r_wb_valid <= 1'b1;
                            r_wb_rd    <= rd_i;
                            r_wb_data  <= alu_res_i;
                        end
                    end
                end
                REQ: begin
                    // A grant in the expiry cycle still counts as a grant.
                    if (gnt_i) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= r_we ? IDLE : WAIT_R;
                    end else if (w_expire) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                WAIT_R: begin
                    if (rvalid_i) begin
                        r_state <= IDLE;
                        if (r_wb_en) begin
                            r_wb_valid <= 1'b1;
                            r_wb_rd    <= r_rd;
                            r_wb_data  <= rdata_i;
                        end
                    end else if (w_expire) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign stall_o    = (r_state != IDLE) | (valid_i & w_is_mem);
    assign req_o      = r_req;
    assign we_o       = r_we;
    assign maddr_o    = r_maddr;
    assign mwdata_o   = r_mwdata;
    assign wb_valid_o = r_wb_valid;
    assign wb_rd_o    = r_wb_rd;
    assign wb_data_o  = r_wb_data;
    assign err_o      = r_err;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios followed by random
// transactions whose expected outcomes come from the instruction-level rules.
module tb_lsu_mem_ctrl;

    localparam int TMO = 8;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        valid_i, mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i;
    logic [31:0] alu_res_i, wdata_i, rdata_i;
    logic [4:0]  rd_i;
    logic        stall_o, req_o, we_o, gnt_i, rvalid_i;
    logic [31:0] maddr_o, mwdata_o, wb_data_o;
    logic        wb_valid_o, err_o;
    logic [4:0]  wb_rd_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    lsu_mem_ctrl #(
        .ADDR_W(32), .DATA_W(32), .RD_W(5), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .mem_to_reg_i(mem_to_reg_i), .reg_write_i(reg_write_i),
        .alu_res_i(alu_res_i), .wdata_i(wdata_i), .rd_i(rd_i),
        .stall_o(stall_o), .req_o(req_o), .we_o(we_o),
        .maddr_o(maddr_o), .mwdata_o(mwdata_o),
        .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        valid_i = 0; mem_read_i = 0; mem_write_i = 0;
        mem_to_reg_i = 0; reg_write_i = 0; gnt_i = 0; rvalid_i = 0;
    endtask

    // ALU op: writeback next cycle iff reg_write and rd != 0; never stalls.
    task automatic alu_op(input bit rw, input logic [4:0] rd, input logic [31:0] res);
        bit exp_wb;
        exp_wb = rw && (rd != 0);
        @(negedge clk_i);
        idle_in();
        valid_i = 1; reg_write_i = rw; rd_i = rd; alu_res_i = res;
        mem_to_reg_i = 1'($urandom);
        #1 chk("alu_stall", 32'(stall_o), 0);
        @(negedge clk_i);
        idle_in();
        #1 chk("alu_wb_valid", 32'(wb_valid_o), 32'(exp_wb));
        chk("alu_stall_wb", 32'(stall_o), 0);
        if (exp_wb) begin
            chk("alu_wb_rd", 32'(wb_rd_o), 32'(rd));
            chk("alu_wb_data", wb_data_o, res);
        end
        @(negedge clk_i);
        #1 chk("alu_wb_pulse", 32'(wb_valid_o), 0);
    endtask

    // Load/store with gd idle REQ cycles before grant and rdl idle WAIT_R
    // cycles before the response (loads only).
    task automatic mem_op(input bit wr, input bit m2r, input bit rw,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input int gd, input int rdl,
                          input logic [31:0] rdat);
        bit exp_wb;
        exp_wb = !wr && m2r && rw && (rd != 0);
        @(negedge clk_i);
        idle_in();
        valid_i = 1; mem_read_i = !wr; mem_write_i = wr;
        mem_to_reg_i = m2r; reg_write_i = rw;
        alu_res_i = addr; wdata_i = wd; rd_i = rd;
        #1 chk("accept_stall", 32'(stall_o), 1);
        chk("accept_no_req", 32'(req_o), 0);
        for (int k = 0; k <= gd; k++) begin
            @(negedge clk_i);
            idle_in();
            alu_res_i = $urandom; wdata_i = $urandom; rd_i = 5'($urandom);
            gnt_i = (k == gd);
            #1 chk("req", 32'(req_o), 1);
            chk("req_we", 32'(we_o), 32'(wr));
            chk("req_maddr", maddr_o, addr);
            if (wr) chk("req_mwdata", mwdata_o, wd);
            chk("req_stall", 32'(stall_o), 1);
        end
        if (!wr) begin
            for (int j = 0; j <= rdl; j++) begin
                @(negedge clk_i);
                idle_in();
                rvalid_i = (j == rdl);
                rdata_i  = (j == rdl) ? rdat : $urandom;
                #1 chk("waitr_req", 32'(req_o), 0);
                chk("waitr_stall", 32'(stall_o), 1);
                chk("waitr_no_wb", 32'(wb_valid_o), 0);
            end
        end
        // Back in IDLE: stray handshake signals must be ignored.
        @(negedge clk_i);
        idle_in();
        gnt_i = 1; rvalid_i = 1; rdata_i = $urandom;
        #1 chk("done_stall", 32'(stall_o), 0);
        chk("done_req", 32'(req_o), 0);
        chk("done_wb_valid", 32'(wb_valid_o), 32'(exp_wb));
        if (exp_wb) begin
            chk("done_wb_rd", 32'(wb_rd_o), 32'(rd));
            chk("done_wb_data", wb_data_o, rdat);
        end
        @(negedge clk_i);
        idle_in();
        #1 chk("stray_no_wb", 32'(wb_valid_o), 0);
        chk("stray_no_req", 32'(req_o), 0);
        chk("stray_no_err", 32'(err_o), 0);
    endtask

    initial begin
        idle_in();
        alu_res_i = 0; wdata_i = 0; rd_i = 0; rdata_i = 0;
        reset_i = 1;
        repeat (2) @(negedge clk_i);
        reset_i = 0;
        #1 chk("rst_req", 32'(req_o), 0);
        chk("rst_we", 32'(we_o), 0);
        chk("rst_maddr", maddr_o, 0);
        chk("rst_mwdata", mwdata_o, 0);
        chk("rst_wb_valid", 32'(wb_valid_o), 0);
        chk("rst_wb_rd", 32'(wb_rd_o), 0);
        chk("rst_wb_data", wb_data_o, 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_stall", 32'(stall_o), 0);

        // Directed: ALU, minimum-latency load, slow store, rd==0 load.
        alu_op(1, 5'd5, 32'h1234);
        alu_op(1, 5'd0, 32'h5555);
        mem_op(0, 1, 1, 32'h40, 32'h0, 5'd7, 0, 0, 32'hDEADBEEF);
        mem_op(1, 0, 0, 32'h80, 32'hA5A5A5A5, 5'd3, 4, 0, 32'h0);
        mem_op(0, 1, 1, 32'h44, 32'h0, 5'd0, 1, 2, 32'hCAFEF00D);

        // Illegal control.
        @(negedge clk_i);
        idle_in();
        valid_i = 1; mem_read_i = 1; mem_write_i = 1; reg_write_i = 1; rd_i = 5'd9;
        #1 chk("ill_stall", 32'(stall_o), 1);
        @(negedge clk_i);
        idle_in();
        #1 chk("ill_err", 32'(err_o), 1);
        chk("ill_req", 32'(req_o), 0);
        chk("ill_wb", 32'(wb_valid_o), 0);
        chk("ill_stall_after", 32'(stall_o), 0);
        @(negedge clk_i);
        #1 chk("ill_err_pulse", 32'(err_o), 0);
        chk("ill_req_after", 32'(req_o), 0);

        // Reset while waiting for load data, then a late response.
        @(negedge clk_i);
        idle_in();
        valid_i = 1; mem_read_i = 1; mem_to_reg_i = 1; reg_write_i = 1;
        rd_i = 5'd12; alu_res_i = 32'h100;
        @(negedge clk_i);
        idle_in(); gnt_i = 1;
        @(negedge clk_i);
        idle_in();
        #1 chk("rml_in_waitr", 32'(stall_o), 1);
        reset_i = 1;
        @(negedge clk_i);
        reset_i = 0;
        rvalid_i = 1; rdata_i = 32'h77777777;
        #1 chk("rml_stall", 32'(stall_o), 0);
        chk("rml_maddr", maddr_o, 0);
        chk("rml_req", 32'(req_o), 0);
        @(negedge clk_i);
        idle_in();
        #1 chk("rml_no_wb", 32'(wb_valid_o), 0);
        chk("rml_wb_data", wb_data_o, 0);
        chk("rml_stall2", 32'(stall_o), 0);

`ifdef LSU_TIMEOUT_EN
        // Grant never arrives: abort after TMO REQ cycles.
        @(negedge clk_i);
        idle_in();
        valid_i = 1; mem_read_i = 1; mem_to_reg_i = 1; reg_write_i = 1;
        rd_i = 5'd4; alu_res_i = 32'h200;
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk_i);
            idle_in();
            #1 chk("tmo_req", 32'(req_o), 1);
            chk("tmo_err_early", 32'(err_o), 0);
        end
        @(negedge clk_i);
        idle_in();
        #1 chk("tmo_req_drop", 32'(req_o), 0);
        chk("tmo_err", 32'(err_o), 1);
        chk("tmo_stall", 32'(stall_o), 0);
        chk("tmo_no_wb", 32'(wb_valid_o), 0);
        @(negedge clk_i);
        idle_in(); rvalid_i = 1; gnt_i = 1;
        #1 chk("tmo_err_pulse", 32'(err_o), 0);
        @(negedge clk_i);
        idle_in();
        #1 chk("tmo_late_no_wb", 32'(wb_valid_o), 0);
        alu_op(1, 5'd6, 32'h600D);
`endif

        // Random transactions.
        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            case (kind)
                0: alu_op(1'($urandom), 5'($urandom_range(0, 31)), $urandom);
                1: mem_op(0, 1'($urandom), 1'($urandom), $urandom, $urandom,
                          5'($urandom_range(0, 31)), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom);
                default: mem_op(1, 1'($urandom), 1'($urandom), $urandom, $urandom,
                                5'($urandom_range(0, 31)), $urandom_range(0, 3),
                                0, $urandom);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
